iopmp_rcd_capture: RTL
======================

# iopmp_rcd_capture

Error-record capture stage directly downstream of the IOPMP entry checker. Accepts violation events from the checker, latches the first one into the 32-bit RCD register image (`iopmp_rcd_t` layout) plus the RCD_ADDR register, and holds it until software clears it. It counts violations lost while a record is held and raises an interrupt when the captured violation's matching entry has its `interrupt` bit set. Outputs feed the register-file read mux at `IOPMP_RCD_OFF` / `IOPMP_RCD_ADDR_OFF`.

## Interface
- `ADDR_WIDTH`, default 32: width of the violating address; must be 32 or less.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `enable_i` in 1: `iopmp_ctl_t.enable`. When 0, events are ignored.
- `irq_en_i` in 1: global interrupt enable.
- `viol_valid_i` in 1: violation event valid.
- `viol_ready_o` out 1: event accept; constantly 1 after reset.
- `viol_sid_i` in 14: source ID.
- `viol_read_i` in 1: 1 = read access, 0 = write access.
- `viol_len_i` in 13: transfer length.
- `viol_addr_i` in ADDR_WIDTH: violating address.
- `viol_intr_i` in 1: `interrupt` bit of the matched entry's `iopmp_entry_t`.
- `sw_clr_i` in 1: single-cycle pulse from a register-file write of `illcgt`=0 to RCD.
- `rcd_o` out 32: `{illcgt, extra[2:0], length[12:0], read, sid[13:0]}`.
- `rcd_addr_o` out 32: captured address, zero-extended.
- `irq_o` out 1: level interrupt.

## Operation
- Accepted event: `viol_valid_i & viol_ready_o & enable_i`. When `enable_i`=0, events are neither captured nor counted, and the held record is retained.
- FSM has two states:
  - EMPTY (reset state): an accepted event captures sid, read, len, addr and intr, then moves to HELD.
  - HELD: `rcd_o.illcgt`=1.
    - An accepted event without `sw_clr_i` leaves the record unchanged and increments the drop counter.
    - `sw_clr_i` without an event clears the record, the counter and irq, then moves to EMPTY.
    - `sw_clr_i` together with an accepted event replaces the record with the new event, zeroes the counter and stays in HELD. irq is recomputed from the new event.
  - `sw_clr_i` in EMPTY has no effect.
- Drop counter is 3 bits and saturates at 7 (no wrap). It is shown in `rcd_o.extra`.
- `irq_o` = HELD & captured intr & `irq_en_i`. The capture part is registered; `irq_en_i` is gated combinationally.
- All fields except `illcgt` read 0 in EMPTY.

## Timing
- Reset values: `rcd_o`=0, `rcd_addr_o`=0, `irq_o`=0, `viol_ready_o`=0 during reset and 1 from the first edge after release. FSM resets to EMPTY, counter to 0.
- Capture latency is 1 cycle: event accepted at edge N, so `rcd_o`, `rcd_addr_o` and `irq_o` are valid after edge N.
- Counter increment is visible 1 cycle after the accepted event.
- `sw_clr_i` takes effect at the next edge; outputs are 0 in the following cycle.
- Back-to-back events in consecutive cycles are all accepted: the first is captured, the rest are counted.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- `IOPMP_RCD_DROP_CNT_EN` defined: the drop counter is present and drives `rcd_o.extra`.
- Not defined: no counter logic is built, `rcd_o.extra` is tied to 3'b000, and all other behaviour is identical.

## Test plan
- Reset then single event (sid=0x12, read=1, len=4, addr=0x8000_1000, intr=1, irq_en=1). Required: next cycle `rcd_o`=0x8002_4012, `rcd_addr_o`=0x8000_1000, `irq_o`=1.
- While HELD, send 9 more events. Required: record unchanged, extra=7 (saturated, with `IOPMP_RCD_DROP_CNT_EN`) or 0 (without).
- Pulse `sw_clr_i` with no event. Required: next cycle `rcd_o`=0, `rcd_addr_o`=0, `irq_o`=0.
- In HELD, pulse `sw_clr_i` together with a new event (sid=0x3, write, intr=0). Required: `rcd_o`=0x8000_0003 (with len=0), extra=0, `irq_o`=0.
- With `enable_i`=0, send an event. Required: `rcd_o` stays 0. With `enable_i`=1 and `irq_en_i`=0, an event with intr=1 is captured with `irq_o`=0, and `irq_o` rises as soon as `irq_en_i`=1.
- Assert `rst_ni` low between clock edges while HELD. Required: all outputs are 0 immediately, and the FSM is EMPTY after release.

Source files
------------

// File: rtl/iopmp_rcd_capture.sv
// IOPMP error-record capture: latches the first violation into the RCD / RCD_ADDR images.
// Optional drop counter built only when IOPMP_RCD_DROP_CNT_EN is defined.
module iopmp_rcd_capture #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  irq_en_i,
  input  logic                  viol_valid_i,
  output logic                  viol_ready_o,
  input  logic [13:0]           viol_sid_i,
  input  logic                  viol_read_i,
  input  logic [12:0]           viol_len_i,
  input  logic [ADDR_WIDTH-1:0] viol_addr_i,
  input  logic                  viol_intr_i,
  input  logic                  sw_clr_i,
  output logic [31:0]           rcd_o,
  output logic [31:0]           rcd_addr_o,
  output logic                  irq_o
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_e;

  state_e                state_q;
  logic                  ready_q;
  logic [13:0]           sid_q;
  logic                  read_q;
  logic [12:0]           len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  intr_q;
  logic [2:0]            extra;
  logic                  accept;

  assign accept = viol_valid_i & ready_q & enable_i;

`ifdef IOPMP_RCD_DROP_CNT_EN
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Saturating increment: lost-event count sticks at 7 rather than wrapping.
  assign cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
  assign extra = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else if (state_q == HELD) begin
      if (sw_clr_i) begin
        cnt_q <= 3'd0;
      end else if (accept) begin
        cnt_q <= cnt_d;
      end
    end
  end
`else
  assign extra = 3'b000;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      sid_q   <= '0;
      read_q  <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      intr_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= HELD;
            sid_q   <= viol_sid_i;
            read_q  <= viol_read_i;
            len_q   <= viol_len_i;
            addr_q  <= viol_addr_i;
            intr_q  <= viol_intr_i;
          end
        end
        HELD: begin
          // A clear that coincides with a new event hands the slot straight to that event.
          if (sw_clr_i && accept) begin
            sid_q  <= viol_sid_i;
            read_q <= viol_read_i;
            len_q  <= viol_len_i;
            addr_q <= viol_addr_i;
            intr_q <= viol_intr_i;
          end else if (sw_clr_i) begin
            state_q <= EMPTY;
            sid_q   <= '0;
            read_q  <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            intr_q  <= 1'b0;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign viol_ready_o = ready_q;
  assign rcd_o        = {(state_q == HELD), extra, len_q, read_q, sid_q};
  assign rcd_addr_o   = 32'(addr_q);
  assign irq_o        = (state_q == HELD) & intr_q & irq_en_i;

endmodule
